// File: rtl/cfo_ctrl_pkg.sv
// Shared types and default constants for the coarse CFO acquisition controller.
package cfo_ctrl_pkg;

   localparam int CFO_FW          = 16;
   localparam int CFO_TMO_SYMS    = 1024;
   localparam int CFO_SETTLE_SYMS = 64;
   localparam int CFO_MAX_RETRY   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACQ,
      ST_GAP,
      ST_SETTLE,
      ST_TRACK,
      ST_FAIL
   } cfo_acq_state_t;

   // Larger of two sizes, used to dimension the shared symbol counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cfo_sym_cnt.sv
// Symbol strobe counter with synchronous clear and a run-time terminal count.
// The terminal-count flag marks the strobe that brings the count to 'limit'.
module cfo_sym_cnt #(
   parameter int CW = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] limit,
   output logic          tc
);

   logic [CW-1:0] cnt;

   // Terminal count fires on the strobe that completes the programmed window.
   assign tc = en && (cnt == (limit - CW'(1)));

   // Count strobes, saturating at the limit so the counter never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != limit)) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/cfo_acq_ctrl.sv
// Coarse CFO acquisition controller: runs the estimator, loads the NCO,
// waits for settling and hands over to the fine carrier loop.
// Optional feature: define CFO_CLAMP_EN to saturate the loaded word to +/-FMAX.
module cfo_acq_ctrl
   import cfo_ctrl_pkg::*;
#(
   parameter int                     FW          = CFO_FW,
   parameter int                     TMO_SYMS    = CFO_TMO_SYMS,
   parameter int                     SETTLE_SYMS = CFO_SETTLE_SYMS,
   parameter int                     MAX_RETRY   = CFO_MAX_RETRY,
   parameter logic signed [FW-1:0]   FMAX        = 16'sd8192
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 sym_vld_i,
   input  logic                 est_done_i,
   input  logic signed [FW-1:0] est_freq_i,
   output logic                 est_en_o,
   output logic signed [FW-1:0] nco_freq_o,
   output logic                 nco_load_o,
   output logic                 fine_en_o,
   output logic                 busy_o,
   output logic                 locked_o,
   output logic                 fail_o
);

   localparam int CW = $clog2(max_int(TMO_SYMS, SETTLE_SYMS) + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [CW-1:0] TMO_LIM    = CW'(TMO_SYMS);
   localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_SYMS);
   localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);

   cfo_acq_state_t        state;
   logic [RW-1:0]         retry_cnt;
   logic                  cnt_active;
   logic                  cnt_en;
   logic                  cnt_clr;
   logic                  cnt_tc;
   logic [CW-1:0]         cnt_limit;
   logic signed [FW-1:0]  freq_sel;

`ifdef CFO_CLAMP_EN
   // Saturate the estimator word to the allowed NCO range before latching.
   always_comb begin
      freq_sel = est_freq_i;
      if (est_freq_i > FMAX) begin
         freq_sel = FMAX;
      end else if (est_freq_i < -FMAX) begin
         freq_sel = -FMAX;
      end
   end
`else
   assign freq_sel = est_freq_i;
`endif

   // The one counter serves the ACQ timeout window and the SETTLE window;
   // it is held clear in every other state and restarted on each exit.
   always_comb begin
      cnt_active = (state == ST_ACQ) || (state == ST_SETTLE);
      cnt_en     = sym_vld_i && cnt_active;
      cnt_limit  = (state == ST_SETTLE) ? SETTLE_LIM : TMO_LIM;
      cnt_clr    = !cnt_active || abort_i || cnt_tc ||
                   ((state == ST_ACQ) && est_done_i);
   end

   cfo_sym_cnt #(
      .CW    (CW)
   ) u_sym_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (cnt_limit),
      .tc    (cnt_tc)
   );

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         retry_cnt  <= '0;
         nco_freq_o <= '0;
         nco_load_o <= 1'b0;
         est_en_o   <= 1'b0;
         fine_en_o  <= 1'b0;
         busy_o     <= 1'b0;
         locked_o   <= 1'b0;
         fail_o     <= 1'b0;
      end else begin
         nco_load_o <= 1'b0;
         if (abort_i) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
            est_en_o  <= 1'b0;
            fine_en_o <= 1'b0;
            busy_o    <= 1'b0;
            locked_o  <= 1'b0;
            fail_o    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_TRACK, ST_FAIL: begin
                  if (start_i) begin
                     state     <= ST_ACQ;
                     retry_cnt <= '0;
                     est_en_o  <= 1'b1;
                     fine_en_o <= 1'b0;
                     busy_o    <= 1'b1;
                     locked_o  <= 1'b0;
                     fail_o    <= 1'b0;
                  end
               end
               ST_ACQ: begin
                  if (est_done_i) begin
                     state      <= ST_SETTLE;
                     nco_freq_o <= freq_sel;
                     nco_load_o <= 1'b1;
                     est_en_o   <= 1'b0;
                  end else if (cnt_tc) begin
                     retry_cnt <= retry_cnt + RW'(1);
                     est_en_o  <= 1'b0;
                     if ((retry_cnt + RW'(1)) < RETRY_LIM) begin
                        state <= ST_GAP;
                     end else begin
                        state  <= ST_FAIL;
                        busy_o <= 1'b0;
                        fail_o <= 1'b1;
                     end
                  end
               end
               ST_GAP: begin
                  state    <= ST_ACQ;
                  est_en_o <= 1'b1;
               end
               ST_SETTLE: begin
                  if (cnt_tc) begin
                     state     <= ST_TRACK;
                     busy_o    <= 1'b0;
                     fine_en_o <= 1'b1;
                     locked_o  <= 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cfo_acq_ctrl.sv
// Directed self-checking bench for cfo_acq_ctrl with default parameters.
// Status vector order: {est_en, nco_load, fine_en, busy, locked, fail}.
module tb_cfo_acq_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start_i = 1'b0;
   logic               abort_i = 1'b0;
   logic               sym_vld_i = 1'b0;
   logic               est_done_i = 1'b0;
   logic signed [15:0] est_freq_i = '0;
   logic               est_en_o;
   logic signed [15:0] nco_freq_o;
   logic               nco_load_o;
   logic               fine_en_o;
   logic               busy_o;
   logic               locked_o;
   logic               fail_o;
   logic [5:0]         flags;

   int checks = 0;
   int failures = 0;
   int load_pulses = 0;

   cfo_acq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .sym_vld_i  (sym_vld_i),
      .est_done_i (est_done_i),
      .est_freq_i (est_freq_i),
      .est_en_o   (est_en_o),
      .nco_freq_o (nco_freq_o),
      .nco_load_o (nco_load_o),
      .fine_en_o  (fine_en_o),
      .busy_o     (busy_o),
      .locked_o   (locked_o),
      .fail_o     (fail_o)
   );

   assign flags = {est_en_o, nco_load_o, fine_en_o, busy_o, locked_o, fail_o};

   // Free-running clock.
   always #5 clk = ~clk;

   // Count every cycle the load strobe is seen high, sampled mid-cycle.
   always @(negedge clk) begin
      if (nco_load_o === 1'b1) load_pulses++;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes(input int n);
      sym_vld_i = 1'b1;
      repeat (n) step();
      sym_vld_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected %b", flags, 6'b000000);
      end
      checks++;
      if (nco_freq_o !== 16'sd0) begin
         failures++;
         $display("[TB] FAIL reset_freq: got %0d expected 0", nco_freq_o);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL idle_flags: got %b expected %b", flags, 6'b000000);
      end
   endtask

   task automatic test_nominal();
      int lp0;
      lp0 = load_pulses;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      checks++;
      if (flags !== 6'b100100) begin
         failures++;
         $display("[TB] FAIL nom_start: got %b expected %b", flags, 6'b100100);
      end
      strobes(200);
      checks++;
      if (flags !== 6'b100100) begin
         failures++;
         $display("[TB] FAIL nom_acq200: got %b expected %b", flags, 6'b100100);
      end
      est_freq_i = 16'sd1234;
      est_done_i = 1'b1;
      step();
      est_done_i = 1'b0;
      checks++;
      if (flags !== 6'b010100) begin
         failures++;
         $display("[TB] FAIL nom_load: got %b expected %b", flags, 6'b010100);
      end
      checks++;
      if (nco_freq_o !== 16'sd1234) begin
         failures++;
         $display("[TB] FAIL nom_freq: got %0d expected 1234", nco_freq_o);
      end
      step();
      checks++;
      if (flags !== 6'b000100) begin
         failures++;
         $display("[TB] FAIL nom_settle: got %b expected %b", flags, 6'b000100);
      end
      strobes(63);
      checks++;
      if (flags !== 6'b000100) begin
         failures++;
         $display("[TB] FAIL nom_settle63: got %b expected %b", flags, 6'b000100);
      end
      strobes(1);
      checks++;
      if (flags !== 6'b001010) begin
         failures++;
         $display("[TB] FAIL nom_track: got %b expected %b", flags, 6'b001010);
      end
      checks++;
      if (load_pulses - lp0 !== 1) begin
         failures++;
         $display("[TB] FAIL nom_pulses: got %0d expected 1", load_pulses - lp0);
      end
   endtask

   task automatic test_timeout_retry();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      checks++;
      if (flags !== 6'b100100) begin
         failures++;
         $display("[TB] FAIL tmo_restart: got %b expected %b", flags, 6'b100100);
      end
      for (int a = 1; a <= 3; a++) begin
         strobes(1023);
         checks++;
         if (flags !== 6'b100100) begin
            failures++;
            $display("[TB] FAIL tmo_pre%0d: got %b expected %b", a, flags, 6'b100100);
         end
         strobes(1);
         if (a < 3) begin
            checks++;
            if (flags !== 6'b000100) begin
               failures++;
               $display("[TB] FAIL tmo_gap%0d: got %b expected %b", a, flags, 6'b000100);
            end
            step();
            checks++;
            if (flags !== 6'b100100) begin
               failures++;
               $display("[TB] FAIL tmo_reacq%0d: got %b expected %b", a, flags, 6'b100100);
            end
         end else begin
            checks++;
            if (flags !== 6'b000001) begin
               failures++;
               $display("[TB] FAIL tmo_fail: got %b expected %b", flags, 6'b000001);
            end
         end
      end
   endtask

   task automatic test_collision();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (2) begin
         strobes(1024);
         step();
      end
      checks++;
      if (flags !== 6'b100100) begin
         failures++;
         $display("[TB] FAIL col_third: got %b expected %b", flags, 6'b100100);
      end
      strobes(1023);
      sym_vld_i = 1'b1;
      est_done_i = 1'b1;
      est_freq_i = -16'sd300;
      step();
      sym_vld_i = 1'b0;
      est_done_i = 1'b0;
      checks++;
      if (flags !== 6'b010100) begin
         failures++;
         $display("[TB] FAIL col_load: got %b expected %b", flags, 6'b010100);
      end
      checks++;
      if (nco_freq_o !== -16'sd300) begin
         failures++;
         $display("[TB] FAIL col_freq: got %0d expected -300", nco_freq_o);
      end
      step();
      strobes(20);
      checks++;
      if (flags !== 6'b000100) begin
         failures++;
         $display("[TB] FAIL col_settle: got %b expected %b", flags, 6'b000100);
      end
   endtask

   task automatic test_abort();
      abort_i = 1'b1;
      start_i = 1'b1;
      est_done_i = 1'b1;
      est_freq_i = 16'sd555;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      est_done_i = 1'b0;
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL abort_flags: got %b expected %b", flags, 6'b000000);
      end
      checks++;
      if (nco_freq_o !== -16'sd300) begin
         failures++;
         $display("[TB] FAIL abort_freq: got %0d expected -300", nco_freq_o);
      end
      step();
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL abort_idle: got %b expected %b", flags, 6'b000000);
      end
   endtask

   task automatic test_clamp();
      logic signed [15:0] exp_freq;
`ifdef CFO_CLAMP_EN
      exp_freq = -16'sd8192;
`else
      exp_freq = -16'sd20000;
`endif
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      strobes(5);
      est_done_i = 1'b1;
      est_freq_i = -16'sd20000;
      step();
      est_done_i = 1'b0;
      checks++;
      if (nco_freq_o !== exp_freq) begin
         failures++;
         $display("[TB] FAIL clamp_freq: got %0d expected %0d", nco_freq_o, exp_freq);
      end
      step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      checks++;
      if (flags !== 6'b000100) begin
         failures++;
         $display("[TB] FAIL settle_ignore_start: got %b expected %b", flags, 6'b000100);
      end
   endtask

   task automatic test_reset_in_acq();
      int lp0;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      checks++;
      if (flags !== 6'b100100) begin
         failures++;
         $display("[TB] FAIL racq_start: got %b expected %b", flags, 6'b100100);
      end
      strobes(30);
      lp0 = load_pulses;
      rst_n = 1'b0;
      est_done_i = 1'b1;
      est_freq_i = 16'sd777;
      step();
      rst_n = 1'b1;
      est_done_i = 1'b0;
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL racq_flags: got %b expected %b", flags, 6'b000000);
      end
      checks++;
      if (nco_freq_o !== 16'sd0) begin
         failures++;
         $display("[TB] FAIL racq_freq: got %0d expected 0", nco_freq_o);
      end
      step();
      checks++;
      if (flags !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL racq_idle: got %b expected %b", flags, 6'b000000);
      end
      checks++;
      if (load_pulses !== lp0) begin
         failures++;
         $display("[TB] FAIL racq_pulses: got %0d expected %0d", load_pulses, lp0);
      end
   endtask

   // Scenario sequence; each task leaves the DUT in the state the next expects.
   initial begin
      $display("[TB] starting cfo_acq_ctrl directed tests");
      test_reset();
      test_nominal();
      test_timeout_retry();
      test_collision();
      test_abort();
      test_clamp();
      test_reset_in_acq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cfo_acq_ctrl.md
CFO_ACQ_CTRL -- requirements
Module: cfo_acq_ctrl

Interface
REQ-001 SHALL have parameter FW, default 16, giving the frequency-word width in bits, signed.
REQ-002 SHALL have parameter TMO_SYMS, default 1024, giving the number of symbol strobes allowed per acquisition attempt.
REQ-003 SHALL have parameter SETTLE_SYMS, default 64, giving the number of symbol strobes between the NCO load and handover to the fine loop.
REQ-004 SHALL have parameter MAX_RETRY, default 3, giving the number of acquisition attempts before failure.
REQ-005 SHALL have parameter FMAX, default 16'sd8192, giving the clamp magnitude; used only with CFO_CLAMP_EN.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port start_i, input, 1 bit: single-cycle request to begin or restart acquisition.
REQ-009 SHALL have port abort_i, input, 1 bit: returns the block to IDLE.
REQ-010 SHALL have port sym_vld_i, input, 1 bit: one strobe per symbol from the timing loop.
REQ-011 SHALL have port est_done_i, input, 1 bit: 1-cycle pulse from the coarse CFO estimator.
REQ-012 SHALL have port est_freq_i, input, FW bits, signed: the estimator freq_word, valid while est_done_i=1.
REQ-013 SHALL have port est_en_o, output, 1 bit: drives the estimator enable.
REQ-014 SHALL have port nco_freq_o, output, FW bits, signed: the held NCO frequency word.
REQ-015 SHALL have port nco_load_o, output, 1 bit: 1-cycle pulse when nco_freq_o updates.
REQ-016 SHALL have port fine_en_o, output, 1 bit: enables the fine carrier loop.
REQ-017 SHALL have ports busy_o, locked_o and fail_o, outputs, 1 bit each: status flags.

Function
REQ-018 SHALL implement the states IDLE, ACQ, GAP, SETTLE, TRACK and FAIL.
REQ-019 SHALL move IDLE->ACQ on start_i; on entry it clears the symbol counter and the retry counter.
REQ-020 SHALL hold est_en_o=1 only in ACQ; est_en_o rises on the cycle after start_i is sampled.
REQ-021 SHALL, in ACQ, count sym_vld_i strobes; the count is ignored when est_done_i is seen.
REQ-022 SHALL, on est_done_i in ACQ, register est_freq_i into nco_freq_o, assert nco_load_o for exactly 1 cycle (the cycle after est_done_i), and go to SETTLE.
REQ-023 SHALL, in ACQ, treat the TMO_SYMS-th strobe without est_done_i as a timeout.
REQ-024 SHALL, on timeout, increment the retry counter, then go to GAP if retries < MAX_RETRY, else to FAIL.
REQ-025 SHALL have GAP last exactly 1 cycle with est_en_o=0 (this restarts the estimator), then return to ACQ with the symbol counter cleared.
REQ-026 SHALL give est_done_i priority when est_done_i and the timeout strobe occur in the same cycle.
REQ-027 SHALL, in SETTLE, count SETTLE_SYMS strobes, then go to TRACK.
REQ-028 SHALL hold fine_en_o=1 and locked_o=1 in TRACK.
REQ-029 SHALL, on start_i in TRACK or FAIL, go to ACQ with the counters cleared; nco_freq_o holds until the next load.
REQ-030 SHALL have abort_i in any state force IDLE on the next cycle, with priority over start_i and est_done_i; nco_freq_o is retained.
REQ-031 SHALL ignore start_i in ACQ, GAP and SETTLE.
REQ-032 SHALL drive busy_o=1 in ACQ, GAP and SETTLE, and fail_o=1 in FAIL only.
REQ-033 SHALL register all outputs, with no combinational path from any input.
REQ-034 SHALL size the counters as $clog2(max+1) and never wrap them.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge, set: state IDLE; both counters 0; nco_freq_o=0; nco_load_o, est_en_o, fine_en_o, busy_o, locked_o and fail_o all 0.
REQ-036 SHALL, on reset mid-acquisition, abandon the attempt without a load pulse.

Configuration
REQ-037 SHALL, with CFO_CLAMP_EN defined, saturate the latched word to [-FMAX, +FMAX] before it drives nco_freq_o.
REQ-038 SHALL, without CFO_CLAMP_EN defined, pass est_freq_i unmodified and leave FMAX unused.

Structure
REQ-039 SHALL place the state enum type cfo_acq_state_t and the default constants for FW, TMO_SYMS, SETTLE_SYMS and MAX_RETRY in package cfo_ctrl_pkg.
REQ-040 SHALL implement the symbol counting, with clear and terminal-count output, in one sub-module, cfo_sym_cnt, instantiated once and shared by ACQ and SETTLE.

Verification
REQ-041 SHALL cover nominal acquisition: start_i, then est_done_i with est_freq_i=16'sd1234 after 200 strobes -> nco_load_o pulses once, nco_freq_o=1234, locked_o=1 after 64 more strobes.
REQ-042 SHALL cover timeout and retry: no est_done_i for 1024 strobes -> est_en_o low for exactly 1 cycle and busy_o stays 1; after 3 timeouts -> fail_o=1 and est_en_o=0.
REQ-043 SHALL cover the collision case: est_done_i on the same cycle as the 1024th strobe -> load occurs, state SETTLE, and the retry count does not increment.
REQ-044 SHALL cover abort: abort_i in SETTLE together with start_i -> IDLE next cycle, all flags 0, nco_freq_o unchanged.
REQ-045 SHALL cover the clamp with CFO_CLAMP_EN defined: est_freq_i=-16'sd20000 -> nco_freq_o=-8192; without the macro -> nco_freq_o=-20000.
REQ-046 SHALL cover reset in ACQ: rst_n=0 for 1 cycle -> all outputs 0 on the next cycle, and no nco_load_o pulse.
